// File: rtl/seq_burst_controller_if.sv
// seq_burst_controller_if: control, generator and stream signals of the burst controller
interface seq_burst_controller_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 16
);
    logic              start;
    logic [LEN_W-1:0]  burst_len;
    logic              abort;
    logic              gen_enable;
    logic [DATA_W-1:0] gen_data;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [LEN_W-1:0]  words_sent;
    modport master (
        input  start, burst_len, abort, gen_data, m_ready,
        output gen_enable, m_data, m_valid, busy, done, aborted, words_sent
    );
    modport slave (
        output start, burst_len, abort, gen_data, m_ready,
        input  gen_enable, m_data, m_valid, busy, done, aborted, words_sent
    );
endinterface

// File: rtl/seq_burst_controller.sv
// seq_burst_controller: pulls bursts from the sequence generator through a FIFO onto a valid/ready stream
module seq_burst_controller #(
    parameter int DATA_W     = 8,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input logic clk,
    input logic reset,
    seq_burst_controller_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t            state, state_n;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  words_sent;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [AW:0]       count, count_n;
    logic              full, push, pop, accept, done, done_n, aborted, aborted_n;
    // full is registered occupancy so a same-cycle pop never opens a slot for a push
    assign full    = count == (AW+1)'(FIFO_DEPTH);
    assign push    = state == RUN && remaining != '0 && !full;
    assign pop     = bus.m_valid && bus.m_ready;
    assign count_n = count + (AW+1)'(push) - (AW+1)'(pop);
    assign bus.gen_enable = push;
    assign bus.m_valid    = count != '0;
    assign bus.m_data     = bus.m_valid ? mem[rd_ptr] : '0;
    assign bus.busy       = state != IDLE;
    assign bus.done       = done;
    assign bus.aborted    = aborted;
    assign bus.words_sent = words_sent;
    // next state, burst acceptance and completion/abort pulses; abort overrides everything
    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        done_n    = 1'b0;
        aborted_n = 1'b0;
        if (bus.abort) begin
            state_n   = IDLE;
            aborted_n = state != IDLE;
        end else begin
            case (state)
                IDLE: begin
                    accept  = bus.start;
                    state_n = bus.start && bus.burst_len != '0 ? RUN : IDLE;
                    done_n  = bus.start && bus.burst_len == '0;
                end
                RUN:     state_n = push && remaining == LEN_W'(1) ? DRAIN : RUN;
                DRAIN: begin
                    state_n = count_n == '0 ? IDLE : DRAIN;
                    done_n  = count_n == '0;
                end
                default: state_n = IDLE;
            endcase
        end
    end
    // state, FIFO pointers, remaining-word counter and stream statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            remaining  <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            words_sent <= '0;
        end else begin
            state   <= state_n;
            done    <= done_n;
            aborted <= aborted_n;
            if (bus.abort) begin
                remaining <= '0;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                count     <= '0;
            end else begin
                if (accept) remaining <= bus.burst_len;
                else if (push) remaining <= remaining - LEN_W'(1);
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                count <= count_n;
            end
            if (accept) words_sent <= '0;
            else if (pop && words_sent != '1) words_sent <= words_sent + LEN_W'(1);
        end
    end
    // FIFO storage; captures the generator word in the same cycle it is advanced
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.gen_data;
    end
endmodule
